// File: rtl/prog_timer_pkg.sv
// Shared types and default widths for the programmable phase timer.
// Imported by the timer top and its prescaler.
package prog_timer_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int PRE_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one tick every div+1 enabled cycles.
// The count is frozen while en is low and cleared by clr.
module tick_prescaler
  import prog_timer_pkg::*;
#(
  parameter int W = PRE_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/prog_phase_timer.sv
// Programmable countdown timer with prescaler, pause and abort.
// Duration is value << freq_sel prescaled ticks.
module prog_phase_timer
  import prog_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [1:0]         freq_sel,
  input  logic [CNT_W-1:0]   value,
  input  logic [PRE_W-1:0]   tick_div,
  output logic [CNT_W+2:0]   remaining,
  output logic               busy,
  output logic               paused,
  output logic               done,
  output logic               expired
);

  localparam int RW = CNT_W + 3;

  state_t           state;
  logic [PRE_W-1:0] div_q;
  logic [RW-1:0]    scaled;
  logic             tick;
  logic             run;

  assign scaled  = {3'b000, value} << freq_sel;
  assign run     = (state == S_RUN);
  assign busy    = (state == S_RUN) || (state == S_PAUSE);
  assign paused  = (state == S_PAUSE);
  assign expired = (state == S_DONE);

  tick_prescaler #(.W(PRE_W)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (start | abort),
    .en   (run),
    .div  (div_q),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      div_q     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        remaining <= '0;
      end else if (start) begin
        div_q     <= tick_div;
        remaining <= scaled;
        if (scaled == '0) begin
          state <= S_DONE;
          done  <= 1'b1;
        end else begin
          state <= S_RUN;
        end
      end else begin
        case (state)
          // A tick landing with pause still counts before freezing.
          S_RUN: begin
            if (tick && remaining == RW'(1)) begin
              remaining <= '0;
              state     <= S_DONE;
              done      <= 1'b1;
            end else begin
              if (tick) remaining <= remaining - RW'(1);
              if (pause) state <= S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (!pause) state <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_phase_timer.sv
// Directed self-checking bench for prog_phase_timer.
// Inputs change 1ns after rising edges; outputs are sampled there too.
module tb_prog_phase_timer;
  import prog_timer_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        pause;
  logic [1:0]  freq_sel;
  logic [31:0] value;
  logic [15:0] tick_div;
  logic [34:0] remaining;
  logic        busy;
  logic        paused;
  logic        done;
  logic        expired;

  int total;
  int passes;
  int n;

  prog_phase_timer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pause     (pause),
    .freq_sel  (freq_sel),
    .value     (value),
    .tick_div  (tick_div),
    .remaining (remaining),
    .busy      (busy),
    .paused    (paused),
    .done      (done),
    .expired   (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic [3:0] exp);
    chk(tag, {60'd0, busy, paused, done, expired}, {60'd0, exp});
  endtask

  // Count edges until done is seen, bounded by max.
  task automatic wait_done(input int max, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!done && cnt < max);
  endtask

  task automatic do_start(input logic [31:0] v, input logic [1:0] f,
                          input logic [15:0] d);
    value    = v;
    freq_sel = f;
    tick_div = d;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    total    = 0;
    passes   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    pause    = 1'b0;
    freq_sel = 2'd0;
    value    = '0;
    tick_div = '0;
    #1;
    chk("reset_rem", {29'd0, remaining}, 64'd0);
    flags("reset_flags", 4'b0000);
    repeat (2) step();
    rst = 1'b1;

    // pause ignored in IDLE
    pause = 1'b1;
    step();
    flags("idle_pause", 4'b0000);
    pause = 1'b0;

    // basic 5-tick countdown; input changes after start ignored
    do_start(32'd5, 2'd0, 16'd0);
    chk("t1_load", {29'd0, remaining}, 64'd5);
    flags("t1_busy", 4'b1000);
    value    = 32'd100;
    freq_sel = 2'd3;
    tick_div = 16'd7;
    repeat (3) step();
    chk("t1_rem2", {29'd0, remaining}, 64'd2);
    wait_done(20, n);
    chk("t1_latency", 64'(n), 64'd2);
    flags("t1_done", 4'b0011);
    chk("t1_rem0", {29'd0, remaining}, 64'd0);
    step();
    flags("t1_expired", 4'b0001);
    repeat (3) step();
    chk("t1_hold", {29'd0, remaining, expired}, 64'd1);

    // scaled load with prescaler
    do_start(32'd3, 2'd3, 16'd1);
    chk("t2_load", {29'd0, remaining}, 64'd24);
    step();
    chk("t2_k1", {29'd0, remaining}, 64'd24);
    step();
    chk("t2_k2", {29'd0, remaining}, 64'd23);
    wait_done(100, n);
    chk("t2_latency", 64'(n), 64'd46);
    flags("t2_done", 4'b0011);

    // pause for 7 cycles
    do_start(32'd10, 2'd0, 16'd0);
    repeat (3) step();
    chk("t3_pre", {29'd0, remaining}, 64'd7);
    pause = 1'b1;
    step();
    chk("t3_tick_kept", {29'd0, remaining}, 64'd6);
    flags("t3_paused", 4'b1100);
    repeat (6) step();
    chk("t3_frozen", {29'd0, remaining}, 64'd6);
    flags("t3_still", 4'b1100);
    pause = 1'b0;
    step();
    chk("t3_resume", {29'd0, remaining}, 64'd6);
    flags("t3_run", 4'b1000);
    wait_done(20, n);
    chk("t3_latency", 64'(n), 64'd6);

    // abort at remaining 4
    do_start(32'd10, 2'd0, 16'd0);
    repeat (6) step();
    chk("t4_pre", {29'd0, remaining}, 64'd4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_rem", {29'd0, remaining}, 64'd0);
    flags("t4_idle", 4'b0000);
    repeat (5) step();
    flags("t4_nodone", 4'b0000);
    abort = 1'b1;
    do_start(32'd5, 2'd0, 16'd0);
    abort = 1'b0;
    chk("t4_both_rem", {29'd0, remaining}, 64'd0);
    flags("t4_both", 4'b0000);

    // zero duration and maximum scaled load
    do_start(32'd0, 2'd2, 16'd0);
    flags("t5_zero", 4'b0011);
    step();
    flags("t5_zero_after", 4'b0001);
    do_start(32'hFFFF_FFFF, 2'd3, 16'd0);
    chk("t5_max", {29'd0, remaining}, 64'h7_FFFF_FFF8);
    flags("t5_max_run", 4'b1000);

    // asynchronous reset mid-run, then nominal restart
    do_start(32'd4, 2'd0, 16'd0);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_rem", {29'd0, remaining}, 64'd0);
    flags("t6_rst_flags", 4'b0000);
    step();
    rst = 1'b1;
    do_start(32'd4, 2'd0, 16'd0);
    chk("t6_load", {29'd0, remaining}, 64'd4);
    wait_done(20, n);
    chk("t6_latency", 64'(n), 64'd4);
    flags("t6_done", 4'b0011);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
